lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store unit that sits directly upstream of the word-addressed data memory in the RISC-V soft core. It accepts byte, halfword and word load/store requests from the MEM pipeline stage, checks alignment and range, and converts byte addresses to word indices. It performs sub-word extraction with sign/zero extension, and implements SB/SH as a read-modify-write, because the data memory has no byte enables. It drives the memory's m_addr/m_wr_dat/rd_en/wr_en/m_rd_dat interface and returns the result to the pipeline through a valid/ready handshake.

Parameters:
DEPTH, 256, number of 32-bit words in the data memory; the word index must be < DEPTH.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request valid from MEM stage
req_ready  out  1  block can accept a request (IDLE only)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (size/sign)
req_addr  in  32  byte address
req_wdata  in  32  store data (LSBs used for SB/SH)
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  pipeline accepts response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned, illegal funct3 or out-of-range access
m_addr  out  32  word index to memory (req_addr[31:2], zero-extended)
m_wr_dat  out  32  write word to memory
rd_en  out  1  memory read strobe
wr_en  out  1  memory write strobe
m_rd_dat  in  32  memory read data, valid the cycle after rd_en

Behaviour:
- Reset (asynchronous, active-high): state = IDLE. All registered outputs are 0: rsp_valid, rsp_rdata, rsp_err, m_addr, m_wr_dat, rd_en, wr_en. req_ready = 1 once reset deasserts.
- Reset mid-operation: the transaction is abandoned. rd_en/wr_en drop immediately. A pending RMW write is never issued. No response is produced.
- All memory-side outputs are registered. rd_en and wr_en are single-cycle pulses and are never both high.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Error conditions:
  - Illegal funct3.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - req_addr[31:2] >= DEPTH.
- States: IDLE, ISSUE_LD, WAIT_LD, WAIT_RMW, WRITE, RESP.
- IDLE:
  - req_ready = 1. On req_valid, latch addr, wdata, funct3 and we.
  - Error -> RESP with rsp_err = 1 and rsp_rdata = 0; no memory access.
  - Load -> rd_en pulse -> WAIT_LD.
  - SW -> wr_en pulse with m_wr_dat = wdata -> RESP.
  - SB/SH -> rd_en pulse -> WAIT_RMW.
- WAIT_LD:
  - Lane = addr[1:0].
  - Byte = m_rd_dat[8*lane+7 : 8*lane]. Halfword = m_rd_dat[16*addr[1]+15 : 16*addr[1]].
  - Sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW.
  - Register the result into rsp_rdata -> RESP.
- WAIT_RMW: merge into m_rd_dat.
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces halfword addr[1] with wdata[15:0].
  - Register the merged word into m_wr_dat -> WRITE.
- WRITE: wr_en pulse -> RESP.
- RESP: rsp_valid = 1, held with stable rsp_rdata/rsp_err until rsp_ready = 1. On that cycle -> IDLE; rsp_valid = 0 the next cycle.
- Latency, counted from the accept cycle 0 (req_valid & req_ready):
  - Error: rsp_valid in cycle 1.
  - SW: wr_en in cycle 1, rsp_valid in cycle 2.
  - Load: rd_en in cycle 1, rsp_valid in cycle 3.
  - SB/SH: rd_en in cycle 1, wr_en in cycle 3, rsp_valid in cycle 4.
- One outstanding request only. A new request can be accepted no earlier than the cycle after the rsp handshake.
- m_rd_dat is ignored outside WAIT_LD/WAIT_RMW. req_* inputs are ignored outside IDLE.

Test Plan:
1. Memory word 3 = 0x8070_F0A5. LB addr 0x0C -> rsp_rdata 0xFFFF_FFA5. LBU 0x0D -> 0x0000_00F0. LH 0x0E -> 0xFFFF_8070. LHU 0x0E -> 0x0000_8070. rsp_valid 3 cycles after accept, rsp_err = 0 each.
2. Word 5 = 0x1122_3344. SB addr 0x16, wdata 0xFFFF_FFAB -> rd_en cycle 1, wr_en cycle 3 with m_addr = 5, m_wr_dat = 0x11AB_3344. Then SH addr 0x14, wdata 0xBEEF -> m_wr_dat 0x11AB_BEEF.
3. SW addr 0x20, wdata 0xDEAD_BEEF -> wr_en cycle 1, m_addr 8, m_wr_dat 0xDEAD_BEEF. LW 0x20 -> 0xDEAD_BEEF.
4. Error cases -> rsp_err = 1, rsp_rdata = 0 in cycle 1, rd_en = wr_en = 0 throughout:
   - LW 0x22.
   - SH 0x13.
   - funct3 = 011.
   - LW at 0x400 (index 256 = DEPTH).
5. rsp_ready held low 4 cycles after a load -> rsp_valid/rsp_rdata stable, req_ready = 0, a second req_valid is ignored. After rsp_ready = 1 the second request is accepted the following cycle.
6. Assert reset in the WAIT_RMW cycle of an SB -> outputs 0 immediately, no wr_en ever, target word unchanged. After release, the next LW returns the original value.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Load/store unit in front of a word-addressed data memory with
//               sub-word extraction and read-modify-write for SB/SH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_ctrl #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] m_addr,
   output logic [31:0] m_wr_dat,
   output logic        rd_en,
   output logic        wr_en,
   input  logic [31:0] m_rd_dat
);

   localparam logic [31:0] C_DEPTH = 32'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ISSUE_LD = 3'd1,
      S_WAIT_LD  = 3'd2,
      S_WAIT_RMW = 3'd3,
      S_WRITE    = 3'd4,
      S_RESP     = 3'd5
   } state_t;

   state_t      state_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;
   logic [2:0]  funct3_q;
   logic        we_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;
   logic [31:0] m_addr_q;
   logic [31:0] m_wr_dat_q;
   logic        rd_en_q;
   logic        wr_en_q;

   logic        req_err_d;
   logic        f3_legal_d;
   logic [7:0]  byte_d;
   logic [15:0] half_d;
   logic [31:0] load_ext_d;
   logic [31:0] merged_d;

   // Request qualification on the live request inputs (used only in IDLE)
   always_comb begin
      f3_legal_d = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: f3_legal_d = 1'b1;
         3'b100, 3'b101:         f3_legal_d = ~req_we;
         default:                f3_legal_d = 1'b0;
      endcase
      req_err_d = ~f3_legal_d
                | ((req_funct3[1:0] == 2'b01) & req_addr[0])
                | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00))
                | ({2'b00, req_addr[31:2]} >= C_DEPTH);
   end

   always_comb begin
      byte_d   = m_rd_dat[7:0];
      merged_d = m_rd_dat;
      case (lane_q)
         2'd0: byte_d = m_rd_dat[7:0];
         2'd1: byte_d = m_rd_dat[15:8];
         2'd2: byte_d = m_rd_dat[23:16];
         default: byte_d = m_rd_dat[31:24];
      endcase
      half_d = lane_q[1] ? m_rd_dat[31:16] : m_rd_dat[15:0];

      case (funct3_q)
         3'b000:  load_ext_d = {{24{byte_d[7]}}, byte_d};
         3'b001:  load_ext_d = {{16{half_d[15]}}, half_d};
         3'b100:  load_ext_d = {24'd0, byte_d};
         3'b101:  load_ext_d = {16'd0, half_d};
         default: load_ext_d = m_rd_dat;
      endcase

      // SB merges one byte lane, SH one halfword; the rest of the word is kept
      if (funct3_q[1:0] == 2'b00) begin
         case (lane_q)
            2'd0: merged_d[7:0]   = wdata_q[7:0];
            2'd1: merged_d[15:8]  = wdata_q[7:0];
            2'd2: merged_d[23:16] = wdata_q[7:0];
            default: merged_d[31:24] = wdata_q[7:0];
         endcase
      end else if (lane_q[1]) begin
         merged_d[31:16] = wdata_q;
      end else begin
         merged_d[15:0] = wdata_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         lane_q      <= 2'd0;
         wdata_q     <= 16'd0;
         funct3_q    <= 3'd0;
         we_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
         m_addr_q    <= 32'd0;
         m_wr_dat_q  <= 32'd0;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  lane_q      <= req_addr[1:0];
                  wdata_q     <= req_wdata[15:0];
                  funct3_q    <= req_funct3;
                  we_q        <= req_we;
                  rsp_rdata_q <= 32'd0;
                  rsp_err_q   <= 1'b0;
                  if (req_err_d) begin
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end else begin
                     m_addr_q <= {2'b00, req_addr[31:2]};
                     if (req_we && (req_funct3[1:0] == 2'b10)) begin
                        m_wr_dat_q <= req_wdata;
                        wr_en_q    <= 1'b1;
                        state_q    <= S_WRITE;
                     end else begin
                        rd_en_q <= 1'b1;
                        state_q <= S_ISSUE_LD;
                     end
                  end
               end
            end
            // Read data appears the cycle after rd_en, so wait one cycle here
            S_ISSUE_LD: state_q <= we_q ? S_WAIT_RMW : S_WAIT_LD;
            S_WAIT_LD: begin
               rsp_rdata_q <= load_ext_d;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_WAIT_RMW: begin
               m_wr_dat_q <= merged_d;
               wr_en_q    <= 1'b1;
               state_q    <= S_WRITE;
            end
            S_WRITE: begin
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == S_IDLE) & ~reset;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign m_addr    = m_addr_q;
   assign m_wr_dat  = m_wr_dat_q;
   assign rd_en     = rd_en_q;
   assign wr_en     = wr_en_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Directed self-checking bench for lsu_mem_ctrl with a
//               word-wide memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] m_addr;
   logic [31:0] m_wr_dat;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] m_rd_dat = 32'd0;

   logic [31:0] mem [0:255];
   int checks = 0;
   int failures = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int both_cnt = 0;

   lsu_mem_ctrl #(.DEPTH(256)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .m_addr(m_addr), .m_wr_dat(m_wr_dat),
      .rd_en(rd_en), .wr_en(wr_en), .m_rd_dat(m_rd_dat)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) begin
         m_rd_dat <= mem[m_addr[7:0]];
         rd_cnt   <= rd_cnt + 1;
      end
      if (wr_en) begin
         mem[m_addr[7:0]] <= m_wr_dat;
         wr_cnt <= wr_cnt + 1;
      end
   end

   always @(negedge clk) if (rd_en && wr_en) both_cnt <= both_cnt + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Leaves the bench #1 into cycle 1 after the accept edge
   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
      for (int i = 0; i < 20 && !req_ready; i++) step();
      chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      step();
      req_valid  = 1'b0;
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] exp_idx, input logic [31:0] exp);
      send(1'b0, f3, addr, 32'd0);
      chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd1);
      chk({tag, "_m_addr"}, m_addr, exp_idx);
      step();
      chk({tag, "_c2_valid"}, {31'd0, rsp_valid}, 32'd0);
      step();
      chk({tag, "_c3_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_rdata"}, rsp_rdata, exp);
      chk({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
      finish_rsp(tag);
   endtask

   task automatic err_check(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr);
      int rb, wb;
      rb = rd_cnt;
      wb = wr_cnt;
      send(we, f3, addr, 32'hFFFF_FFFF);
      chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_err"}, {31'd0, rsp_err}, 32'd1);
      chk({tag, "_rdata"}, rsp_rdata, 32'd0);
      finish_rsp(tag);
      chk({tag, "_no_rd"}, 32'(rd_cnt - rb), 32'd0);
      chk({tag, "_no_wr"}, 32'(wr_cnt - wb), 32'd0);
   endtask

   initial begin
      int rb, wb;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[3]   = 32'h8070_F0A5;
      mem[5]   = 32'h1122_3344;
      mem[255] = 32'hCAFE_0255;

      // Reset state
      step();
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_m_wr_dat", m_wr_dat, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);

      // Sub-word loads with extension
      load_check("lb",  3'b000, 32'h0C, 32'd3, 32'hFFFF_FFA5);
      load_check("lbu", 3'b100, 32'h0D, 32'd3, 32'h0000_00F0);
      load_check("lh",  3'b001, 32'h0E, 32'd3, 32'hFFFF_8070);
      load_check("lhu", 3'b101, 32'h0E, 32'd3, 32'h0000_8070);

      // SB read-modify-write
      send(1'b1, 3'b000, 32'h16, 32'hFFFF_FFAB);
      chk("sb_rd_en", {31'd0, rd_en}, 32'd1);
      chk("sb_c1_wr_en", {31'd0, wr_en}, 32'd0);
      chk("sb_m_addr_rd", m_addr, 32'd5);
      step();
      chk("sb_c2_rd_en", {31'd0, rd_en}, 32'd0);
      chk("sb_c2_wr_en", {31'd0, wr_en}, 32'd0);
      step();
      chk("sb_c3_wr_en", {31'd0, wr_en}, 32'd1);
      chk("sb_m_addr_wr", m_addr, 32'd5);
      chk("sb_m_wr_dat", m_wr_dat, 32'h11AB_3344);
      chk("sb_c3_valid", {31'd0, rsp_valid}, 32'd0);
      step();
      chk("sb_c4_valid", {31'd0, rsp_valid}, 32'd1);
      chk("sb_c4_wr_en", {31'd0, wr_en}, 32'd0);
      chk("sb_rdata", rsp_rdata, 32'd0);
      chk("sb_err", {31'd0, rsp_err}, 32'd0);
      finish_rsp("sb");

      // SH read-modify-write on the same word
      send(1'b1, 3'b001, 32'h14, 32'h0000_BEEF);
      chk("sh_rd_en", {31'd0, rd_en}, 32'd1);
      step();
      step();
      chk("sh_wr_en", {31'd0, wr_en}, 32'd1);
      chk("sh_m_wr_dat", m_wr_dat, 32'h11AB_BEEF);
      step();
      chk("sh_valid", {31'd0, rsp_valid}, 32'd1);
      finish_rsp("sh");
      chk("sh_mem", mem[5], 32'h11AB_BEEF);

      // SW then LW
      send(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
      chk("sw_wr_en", {31'd0, wr_en}, 32'd1);
      chk("sw_rd_en", {31'd0, rd_en}, 32'd0);
      chk("sw_m_addr", m_addr, 32'd8);
      chk("sw_m_wr_dat", m_wr_dat, 32'hDEAD_BEEF);
      chk("sw_c1_valid", {31'd0, rsp_valid}, 32'd0);
      step();
      chk("sw_c2_valid", {31'd0, rsp_valid}, 32'd1);
      chk("sw_c2_wr_en", {31'd0, wr_en}, 32'd0);
      finish_rsp("sw");
      load_check("lw", 3'b010, 32'h20, 32'd8, 32'hDEAD_BEEF);
      load_check("lw_last", 3'b010, 32'h3FC, 32'd255, 32'hCAFE_0255);

      // Error cases
      err_check("e_lw_mis", 1'b0, 3'b010, 32'h22);
      err_check("e_sh_mis", 1'b1, 3'b001, 32'h13);
      err_check("e_f3_011", 1'b0, 3'b011, 32'h00);
      err_check("e_sbu",    1'b1, 3'b100, 32'h00);
      err_check("e_range",  1'b0, 3'b010, 32'h400);

      // Back-pressure on the response; second request must wait
      send(1'b0, 3'b010, 32'h20, 32'd0);
      step();
      step();
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0C;
      rb = rd_cnt;
      for (int i = 0; i < 4; i++) begin
         chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
         step();
      end
      chk("bp_no_rd", 32'(rd_cnt - rb), 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("bp_drop", {31'd0, rsp_valid}, 32'd0);
      chk("bp_ready_again", {31'd0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      chk("bp2_rd_en", {31'd0, rd_en}, 32'd1);
      chk("bp2_m_addr", m_addr, 32'd3);
      step();
      step();
      chk("bp2_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp2_rdata", rsp_rdata, 32'h8070_F0A5);
      finish_rsp("bp2");

      // Reset during WAIT_RMW of an SB
      send(1'b1, 3'b000, 32'h16, 32'h0000_0055);
      chk("rr_rd_en", {31'd0, rd_en}, 32'd1);
      step();
      wb = wr_cnt;
      reset = 1'b1;
      #1;
      chk("rr_rd_en0", {31'd0, rd_en}, 32'd0);
      chk("rr_wr_en0", {31'd0, wr_en}, 32'd0);
      chk("rr_m_addr0", m_addr, 32'd0);
      chk("rr_m_wr_dat0", m_wr_dat, 32'd0);
      chk("rr_valid0", {31'd0, rsp_valid}, 32'd0);
      step();
      step();
      reset = 1'b0;
      step();
      step();
      chk("rr_no_wr", 32'(wr_cnt - wb), 32'd0);
      chk("rr_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("rr_mem", mem[5], 32'h11AB_BEEF);
      load_check("rr_lw", 3'b010, 32'h14, 32'd5, 32'h11AB_BEEF);

      chk("never_both_en", 32'(both_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
